insn_sequencer: RTL
===================

INSN_SEQUENCER -- requirements
Module: insn_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: run  input  1  enables instruction fetch; sampled in IDLE and at instruction end.
REQ-004 SHALL have port: ram_addr  output  8  fetch address, equal to pc during FETCH, else 0.
REQ-005 SHALL have port: ram_rd_en  output  1  fetch read strobe, high only in FETCH.
REQ-006 SHALL have port: ram_rdata  input  8  instruction byte, valid the cycle after ram_rd_en.
REQ-007 SHALL have port: insn_done  input  1  from bus_control, high in the last cycle of the executing instruction.
REQ-008 SHALL have port: pc_load  input  1  PC write request from the datapath; pc_load_val  input  8  its value.
REQ-009 SHALL have port: insn_en  output  ISA_INSN_COUNT  one-hot decoded instruction to bus_control.
REQ-010 SHALL have port: reg_num  output  3  register field insn[2:0]; imm  output  3  same field as immediate.
REQ-011 SHALL have port: pc  output  8  current program counter.
REQ-012 SHALL have ports: illegal  output  1  one-cycle pulse; halted  output  1  level.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_DATA, DECODE, EXEC, HALT.
REQ-014 IDLE: SHALL go to FETCH when run=1, else stay.
REQ-015 FETCH: SHALL drive ram_rd_en=1, ram_addr=pc; next state WAIT_DATA.
REQ-016 WAIT_DATA: SHALL capture ram_rdata into an 8-bit instruction register; next state DECODE.
REQ-017 DECODE: opcode=ir[7:3]; SHALL register insn_en with bit[opcode] set, plus reg_num/imm=ir[2:0]; next state EXEC.
REQ-018 DECODE, opcode=ISA_HALT (5'h1F): SHALL enter HALT with insn_en=0; halted=1 until reset.
REQ-019 DECODE, opcode>=ISA_INSN_COUNT and not HALT: SHALL pulse illegal for one cycle, keep insn_en=0, pc<=pc+1, go to FETCH if run else IDLE.
REQ-020 EXEC: SHALL hold insn_en, reg_num and imm stable until the cycle insn_done=1.
REQ-021 On insn_done in EXEC: pc<=pc_load_val if pc_load, else pc+1; next state FETCH if run, else IDLE; insn_en cleared next cycle.
REQ-022 pc_load SHALL be ignored outside EXEC; pc_load without insn_done SHALL be ignored.
REQ-023 pc increment SHALL wrap 8'hFF to 8'h00.
REQ-024 insn_en SHALL be zero in every state except EXEC, and never have more than one bit set.
REQ-025 Minimum instruction period: 4 cycles (FETCH, WAIT_DATA, DECODE, EXEC with insn_done on first EXEC cycle).
REQ-026 run deasserted mid-instruction SHALL NOT abort it; sequencer finishes, updates pc, then enters IDLE.
REQ-027 insn_done outside EXEC SHALL be ignored.

Reset
REQ-028 On rst=1: state=IDLE, pc=0, ir=0, insn_en=0, reg_num=0, imm=0, ram_rd_en=0, ram_addr=0, illegal=0, halted=0; rst SHALL override all other inputs, in any state including HALT.

Configuration
REQ-029 Macro INSN_SEQ_WATCHDOG_EN defined: a 4-bit counter SHALL count EXEC cycles; the 16th consecutive EXEC cycle without insn_done SHALL pulse illegal, clear insn_en, set pc<=pc+1 and go to FETCH/IDLE per run.
REQ-030 Macro undefined: no counter; EXEC SHALL wait indefinitely for insn_done.

Structure
REQ-031 ISA_INSN_COUNT, all ISA_<op> opcode indices, ISA_HALT and the state encoding SHALL live in the shared ISA package, shared with the decoder and bus_control.
REQ-032 Opcode-to-one-hot decode SHALL be a sub-module insn_decode (combinational; ir in, insn_en/reg_num/illegal/halt out), registered in insn_sequencer.

Verification
REQ-033 rst, run=1, RAM[0]=ISA_ADD<<3|3'd5, insn_done on first EXEC cycle -> ram_rd_en cycle 1, insn_en[ISA_ADD]=1 and reg_num=5 in cycle 4, pc=1 in cycle 5.
REQ-034 RAM[0x10]=LB with insn_done delayed 2 cycles -> insn_en[ISA_LB] held 3 cycles, pc 0x10->0x11.
REQ-035 pc_load=1, pc_load_val=0x40 together with insn_done -> next FETCH ram_addr=0x40; pc_load alone in EXEC -> pc unchanged.
REQ-036 pc=0xFF, instruction completes -> pc=0x00; opcode 5'h1E (>=ISA_INSN_COUNT) -> illegal one-cycle pulse, insn_en=0, pc+1.
REQ-037 RAM[2]=8'hF8 (HALT) -> halted=1, no further ram_rd_en; rst=1 -> halted=0, pc=0, state IDLE.
REQ-038 INSN_SEQ_WATCHDOG_EN defined, insn_done never asserted -> illegal pulses after 16 EXEC cycles, pc+1, refetch; undefined -> still in EXEC after 100 cycles.

Source files
------------

// File: rtl/insn_sequencer_pkg.sv
// Shared ISA definitions: opcode indices, one-hot width, HALT opcode and
// the sequencer state encoding used by the sequencer, decoder and bus_control.
package insn_sequencer_pkg;

  localparam int ISA_INSN_COUNT = 16;

  localparam logic [4:0] ISA_NOP  = 5'd0;
  localparam logic [4:0] ISA_ADD  = 5'd1;
  localparam logic [4:0] ISA_SUB  = 5'd2;
  localparam logic [4:0] ISA_AND  = 5'd3;
  localparam logic [4:0] ISA_OR   = 5'd4;
  localparam logic [4:0] ISA_XOR  = 5'd5;
  localparam logic [4:0] ISA_LI   = 5'd6;
  localparam logic [4:0] ISA_LB   = 5'd7;
  localparam logic [4:0] ISA_SB   = 5'd8;
  localparam logic [4:0] ISA_JMP  = 5'd9;
  localparam logic [4:0] ISA_JZ   = 5'd10;
  localparam logic [4:0] ISA_MOV  = 5'd11;
  localparam logic [4:0] ISA_SHL  = 5'd12;
  localparam logic [4:0] ISA_SHR  = 5'd13;
  localparam logic [4:0] ISA_CMP  = 5'd14;
  localparam logic [4:0] ISA_OUT  = 5'd15;
  localparam logic [4:0] ISA_HALT = 5'h1F;

  // First opcode value with no one-hot slot; everything from here up (except HALT) is illegal.
  localparam logic [4:0] ISA_OPCODE_LIMIT = 5'(ISA_INSN_COUNT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXEC      = 3'd4,
    ST_HALT      = 3'd5
  } seq_state_e;

  function automatic logic [7:0] pc_inc(input logic [7:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/insn_sequencer_decode.sv
// Combinational instruction decoder: opcode ir[7:3] to one-hot enable,
// register/immediate field ir[2:0], plus illegal and halt flags.
module insn_decode
  import insn_sequencer_pkg::*;
(
  input  logic [7:0]                ir_i,
  output logic [ISA_INSN_COUNT-1:0] insn_en_o,
  output logic [2:0]                reg_num_o,
  output logic                      illegal_o,
  output logic                      halt_o
);

  logic [4:0] opcode;

  always_comb begin
    opcode    = ir_i[7:3];
    reg_num_o = ir_i[2:0];
    insn_en_o = '0;
    illegal_o = 1'b0;
    halt_o    = 1'b0;
    if (opcode == ISA_HALT) begin
      halt_o = 1'b1;
    end else if (opcode >= ISA_OPCODE_LIMIT) begin
      illegal_o = 1'b1;
    end else begin
      for (int i = 0; i < ISA_INSN_COUNT; i++) begin
        insn_en_o[i] = (opcode == 5'(i));
      end
    end
  end

endmodule

// File: rtl/insn_sequencer.sv
// Instruction sequencer: fetch/decode/execute FSM driving bus_control.
// Optional EXEC watchdog enabled by defining INSN_SEQ_WATCHDOG_EN.
module insn_sequencer
  import insn_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  output logic [7:0]                ram_addr,
  output logic                      ram_rd_en,
  input  logic [7:0]                ram_rdata,
  input  logic                      insn_done,
  input  logic                      pc_load,
  input  logic [7:0]                pc_load_val,
  output logic [ISA_INSN_COUNT-1:0] insn_en,
  output logic [2:0]                reg_num,
  output logic [2:0]                imm,
  output logic [7:0]                pc,
  output logic                      illegal,
  output logic                      halted
);

  seq_state_e                state_q;
  logic [7:0]                pc_q;
  logic [7:0]                pc_d;
  logic [7:0]                ir_q;
  logic [7:0]                ram_addr_q;
  logic                      ram_rd_en_q;
  logic                      illegal_q;
  logic                      illegal_d;
  logic                      halted_q;
  logic                      insn_end_d;
  logic                      wd_expire_d;
  logic [ISA_INSN_COUNT-1:0] insn_en_q;
  logic [2:0]                reg_num_q;
  logic [2:0]                imm_q;

  logic [ISA_INSN_COUNT-1:0] dec_insn_en;
  logic [2:0]                dec_reg_num;
  logic                      dec_illegal;
  logic                      dec_halt;

  insn_decode u_decode (
    .ir_i      (ir_q),
    .insn_en_o (dec_insn_en),
    .reg_num_o (dec_reg_num),
    .illegal_o (dec_illegal),
    .halt_o    (dec_halt)
  );

`ifdef INSN_SEQ_WATCHDOG_EN
  logic [3:0] wd_q;
  // wd_q is zero on the first EXEC cycle, so 4'hF marks the 16th cycle.
  assign wd_expire_d = (state_q == ST_EXEC) && !insn_done && (wd_q == 4'hF);
`else
  assign wd_expire_d = 1'b0;
`endif

  // End-of-instruction detection and the pc value that results from it.
  always_comb begin
    insn_end_d = 1'b0;
    illegal_d  = 1'b0;
    pc_d       = pc_q;
    case (state_q)
      ST_DECODE: begin
        if (dec_illegal) begin
          insn_end_d = 1'b1;
          illegal_d  = 1'b1;
          pc_d       = pc_inc(pc_q);
        end else begin
          insn_end_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (insn_done) begin
          insn_end_d = 1'b1;
          pc_d       = pc_load ? pc_load_val : pc_inc(pc_q);
        end else if (wd_expire_d) begin
          insn_end_d = 1'b1;
          illegal_d  = 1'b1;
          pc_d       = pc_inc(pc_q);
        end else begin
          insn_end_d = 1'b0;
        end
      end
      default: begin
        insn_end_d = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= 8'h00;
      ir_q        <= 8'h00;
      insn_en_q   <= '0;
      reg_num_q   <= 3'd0;
      imm_q       <= 3'd0;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= 8'h00;
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
`ifdef INSN_SEQ_WATCHDOG_EN
      wd_q        <= 4'd0;
`endif
    end else begin
      pc_q        <= pc_d;
      illegal_q   <= illegal_d;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= 8'h00;
      if (insn_end_d) begin
        // run is resampled here, so dropping it mid-instruction only stops the next fetch.
        insn_en_q <= '0;
        if (run) begin
          state_q     <= ST_FETCH;
          ram_rd_en_q <= 1'b1;
          ram_addr_q  <= pc_d;
        end else begin
          state_q <= ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run) begin
              state_q     <= ST_FETCH;
              ram_rd_en_q <= 1'b1;
              ram_addr_q  <= pc_q;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_FETCH: begin
            state_q <= ST_WAIT_DATA;
          end
          ST_WAIT_DATA: begin
            ir_q    <= ram_rdata;
            state_q <= ST_DECODE;
          end
          ST_DECODE: begin
            if (dec_halt) begin
              state_q   <= ST_HALT;
              halted_q  <= 1'b1;
              insn_en_q <= '0;
            end else begin
              state_q   <= ST_EXEC;
              insn_en_q <= dec_insn_en;
              reg_num_q <= dec_reg_num;
              imm_q     <= dec_reg_num;
`ifdef INSN_SEQ_WATCHDOG_EN
              wd_q      <= 4'd0;
`endif
            end
          end
          ST_EXEC: begin
            state_q <= ST_EXEC;
`ifdef INSN_SEQ_WATCHDOG_EN
            wd_q    <= wd_q + 4'd1;
`endif
          end
          ST_HALT: begin
            state_q <= ST_HALT;
          end
          default: begin
            state_q   <= ST_IDLE;
            insn_en_q <= '0;
          end
        endcase
      end
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_rd_en = ram_rd_en_q;
  assign insn_en   = insn_en_q;
  assign reg_num   = reg_num_q;
  assign imm       = imm_q;
  assign pc        = pc_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

endmodule
